// File: rtl/mem_a_loader.sv
// mem_a_loader: write-side front end for the skewed A-matrix buffer.
// It packs valid/ready host words into DIM-element rows and issues one row
// write per completed row. After the last row it raises shift_en for
// SHIFT_CYCLES cycles, then pulses done.
// Optional feature macro: MEM_A_LOADER_PAD_EN. When it is defined, the
// in_last input is added and a tile may end early. Any rows that were not
// sent are then written as zero.
module mem_a_loader #(
  parameter int BITS_AB      = 8,
  parameter int DIM          = 8,
  parameter int WORD_BITS    = 32,
  parameter int SHIFT_CYCLES = 2*DIM-1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_BITS-1:0]     in_data,
`ifdef MEM_A_LOADER_PAD_EN
  input  logic                     in_last,
`endif
  output logic                     WrEn,
  output logic [$clog2(DIM)-1:0]   Arow,
  output logic [DIM*BITS_AB-1:0]   Ain,
  output logic                     shift_en,
  output logic                     busy,
  output logic                     done
);

  localparam int EPW = WORD_BITS / BITS_AB;          // elements per word
  localparam int WPR = DIM / EPW;                    // words per row
  localparam int RW  = $clog2(DIM);
  localparam int WCW = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int SCW = $clog2(SHIFT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t                 state_q;
  logic [WCW-1:0]         word_cnt_q;
  logic [RW-1:0]          row_cnt_q;
  logic [SCW-1:0]         shift_cnt_q;
  logic [DIM*BITS_AB-1:0] row_buf_q;
  logic [DIM*BITS_AB-1:0] row_d;
  logic                   wr_en_q;
  logic [RW-1:0]          arow_q;
  logic [DIM*BITS_AB-1:0] ain_q;
  logic                   shift_en_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   pad_q;
  logic                   beat;
  logic                   last_word;
  logic                   last_row;
  logic                   early_end;
  logic                   row_end;

`ifdef MEM_A_LOADER_PAD_EN
  // in_last on any row but the final one closes that row early.
  assign early_end = in_last & ~last_row;
`else
  assign early_end = 1'b0;
`endif

  // Stall the host while the zero rows of an early-ended tile are written.
  assign in_ready  = (state_q == LOAD) & ~pad_q;
  assign beat      = in_valid & in_ready;
  assign last_word = (word_cnt_q == WCW'(WPR - 1));
  assign last_row  = (row_cnt_q == RW'(DIM - 1));
  assign row_end   = beat & (last_word | early_end);

  // Merge the incoming word into its slot of the partial row. Slots above the
  // current word are still zero, so an early-ended row comes out zero-filled.
  for (genvar gi = 0; gi < WPR; gi++) begin : g_word
    assign row_d[gi*WORD_BITS +: WORD_BITS] =
      (word_cnt_q == WCW'(gi)) ? in_data : row_buf_q[gi*WORD_BITS +: WORD_BITS];
  end

  // Tile FSM with all outputs registered; write and shift phases never overlap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      row_cnt_q   <= '0;
      shift_cnt_q <= '0;
      row_buf_q   <= '0;
      wr_en_q     <= 1'b0;
      arow_q      <= '0;
      ain_q       <= '0;
      shift_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pad_q       <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= LOAD;
            busy_q     <= 1'b1;
            word_cnt_q <= '0;
            row_cnt_q  <= '0;
            arow_q     <= '0;
            row_buf_q  <= '0;
            pad_q      <= 1'b0;
          end
        end
        LOAD: begin
          if (pad_q) begin
            // Write one all-zero row per cycle until the tile is full.
            wr_en_q   <= 1'b1;
            ain_q     <= '0;
            arow_q    <= row_cnt_q;
            row_cnt_q <= row_cnt_q + 1'b1;
            if (last_row) begin
              pad_q       <= 1'b0;
              state_q     <= SHIFT;
              shift_cnt_q <= '0;
            end
          end else if (beat) begin
            if (row_end) begin
              wr_en_q    <= 1'b1;
              ain_q      <= row_d;
              arow_q     <= row_cnt_q;
              row_cnt_q  <= row_cnt_q + 1'b1;
              word_cnt_q <= '0;
              row_buf_q  <= '0;
              if (last_row) begin
                state_q     <= SHIFT;
                shift_cnt_q <= '0;
              end else if (early_end) begin
                pad_q <= 1'b1;
              end
            end else begin
              row_buf_q  <= row_d;
              word_cnt_q <= word_cnt_q + 1'b1;
            end
          end
        end
        SHIFT: begin
          // The first SHIFT cycle carries the last row write, so shifting
          // starts on the following cycle.
          if (shift_cnt_q == SCW'(SHIFT_CYCLES)) begin
            shift_en_q <= 1'b0;
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            shift_en_q  <= 1'b1;
            shift_cnt_q <= shift_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign WrEn     = wr_en_q;
  assign Arow     = arow_q;
  assign Ain      = ain_q;
  assign shift_en = shift_en_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mem_a_loader.sv
// tb_mem_a_loader: randomized scoreboard bench for mem_a_loader.
// The stimulus queues the expected row writes.
// A negedge monitor pops the queue on every WrEn. It also follows a
// cycle-level tile model that sets the expected control outputs.
module tb_mem_a_loader;
  localparam int BITS_AB = 8;
  localparam int DIM     = 8;
  localparam int WB      = 32;
  localparam int SHC     = 2*DIM-1;
  localparam int EPW     = WB / BITS_AB;
  localparam int WPR     = DIM / EPW;
`ifdef MEM_A_LOADER_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [WB-1:0]           in_data = '0;
  logic                    in_last = 1'b0;
  logic                    WrEn;
  logic [$clog2(DIM)-1:0]  Arow;
  logic [DIM*BITS_AB-1:0]  Ain;
  logic                    shift_en, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  int               exp_row_q[$];
  logic [63:0]      exp_dat_q[$];
  logic [7:0]       el [DIM][DIM];

  always #5 clk = ~clk;

  mem_a_loader #(.BITS_AB(BITS_AB), .DIM(DIM), .WORD_BITS(WB), .SHIFT_CYCLES(SHC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data),
`ifdef MEM_A_LOADER_PAD_EN
    .in_last(in_last),
`endif
    .WrEn(WrEn), .Arow(Arow), .Ain(Ain), .shift_en(shift_en), .busy(busy), .done(done));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor: tile model + scoreboard ----------------
  int ph = 0;               // 0 idle, 1 load, 2 shift
  int m_row, m_word, m_pad, m_k;
  bit m_valid = 0, c_wr = 0, c_done = 0, c_rst = 0;

  always @(negedge clk) begin
    bit rdy, nwr, ndone, lst;
    int er;
    logic [63:0] ed;
    if (m_valid) begin
      rdy = (ph == 1) && (m_pad == 0);
      chk("ctrl{ready,wren,shift,busy,done}", {59'd0, in_ready, WrEn, shift_en, busy, done},
          {59'd0, rdy, c_wr, (ph == 2) && (m_k >= 1), ph != 0, c_done});
      if (c_rst) begin
        chk("reset_arow", Arow, 0);
        chk("reset_ain", Ain, 0);
      end
      if (WrEn === 1'b1) begin
        chk("wr_expected", exp_row_q.size() != 0, 1);
        if (exp_row_q.size() != 0) begin
          er = exp_row_q.pop_front();
          ed = exp_dat_q.pop_front();
          chk("arow", Arow, er);
          chk("ain", Ain, ed);
          $display("row write: Arow=%0d Ain=%h", Arow, Ain);
        end
      end
    end
    nwr = 0; ndone = 0;
    if (!rst_n) begin
      ph = 0; m_row = 0; m_word = 0; m_pad = 0; m_k = 0;
      m_valid = 1; c_wr = 0; c_done = 0; c_rst = 1;
    end else if (m_valid) begin
      c_rst = 0;
      case (ph)
        0: if (start) begin ph = 1; m_row = 0; m_word = 0; m_pad = 0; end
        1: begin
          if (m_pad > 0) begin
            nwr = 1; m_pad--; m_row++;
            if (m_row == DIM) begin ph = 2; m_k = 0; end
          end else if (in_valid) begin
            lst = PAD && in_last && (m_row < DIM-1);
            m_word++;
            if (m_word == WPR || lst) begin
              nwr = 1; m_word = 0; m_row++;
              if (m_row == DIM) begin ph = 2; m_k = 0; end
              else if (lst) m_pad = DIM - m_row;
            end
          end
        end
        default: begin
          if (m_k == SHC) begin ph = 0; ndone = 1; end
          else m_k++;
        end
      endcase
      c_wr = nwr; c_done = ndone;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_row(input int r);
    logic [63:0] d;
    for (int e = 0; e < DIM; e++) d[e*8 +: 8] = el[r][e];
    exp_row_q.push_back(r);
    exp_dat_q.push_back(d);
  endtask

  task automatic drive_word(input logic [WB-1:0] d, input bit last);
    bit acc;
    int n;
    in_valid = 1; in_data = d; in_last = last; n = 0;
    do begin
      @(negedge clk); acc = in_ready; tick(); n++;
    end while (!acc && n < 200);
    in_valid = 0; in_last = 0;
    chk("word_accepted", acc, 1);
  endtask

  // mode 0: 8r+e, 1: 0x80+e, 2: random. gap 0: none, 1: every other, 2: random.
  // lr/lw: in_last position (-1 none). abort: reset after this many beats (-1 none).
  task automatic run_tile(input int mode, input int gap, input bit spam,
                          input int lr, input int lw, input int abort);
    logic [WB-1:0] w;
    bit stop, seen, eff;
    int g, beats;
    for (int r = 0; r < DIM; r++)
      for (int e = 0; e < DIM; e++)
        el[r][e] = (mode == 0) ? 8'(8*r + e) : (mode == 1) ? 8'(8'h80 + e) : 8'($urandom);
    eff = PAD && (lr >= 0) && (lr < DIM-1);
    if (eff) begin
      for (int e = (lw+1)*EPW; e < DIM; e++) el[lr][e] = 8'd0;
      for (int r = lr+1; r < DIM; r++)
        for (int e = 0; e < DIM; e++) el[r][e] = 8'd0;
    end
    start = 1; tick(); start = 0;
    stop = 0; beats = 0;
    for (int r = 0; r < DIM && !stop; r++) begin
      for (int wi = 0; wi < WPR && !stop; wi++) begin
        g = (gap == 0) ? 0 : (gap == 1) ? 1 : int'($urandom_range(0, 2));
        repeat (g) begin start = spam ? 1'($urandom) : 1'b0; tick(); end
        start = 0;
        for (int j = 0; j < EPW; j++) w[j*8 +: 8] = el[r][wi*EPW + j];
        drive_word(w, (r == lr) && (wi == lw));
        beats++;
        if (eff && r == lr && wi == lw) begin
          for (int rr = r; rr < DIM; rr++) push_row(rr);
          stop = 1;
        end else if (wi == WPR-1) begin
          push_row(r);
        end
        if (abort >= 0 && beats == abort) begin
          rst_n = 0; repeat (3) tick();
          exp_row_q.delete(); exp_dat_q.delete();
          rst_n = 1;
          return;
        end
      end
    end
    if (spam) repeat (4) begin start = ~start; tick(); end
    start = 0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk); seen = done;
    end
    chk("done_seen", seen, 1);
    tick(); tick();
    chk("scoreboard_drained", exp_row_q.size(), 0);
    $display("tile done: mode=%0d gap=%0d spam=%0d last=(%0d,%0d)", mode, gap, spam, lr, lw);
  endtask

  initial begin
    in_valid = 1; start = 1;
    repeat (3) tick();
    rst_n = 1; in_valid = 0; start = 0;
    tick();
    run_tile(0, 0, 0, -1, -1, -1);
    run_tile(0, 1, 0, -1, -1, -1);
    run_tile(2, 2, 1, -1, -1, -1);
    run_tile(0, 0, 0, -1, -1, 5);
    run_tile(1, 0, 0, -1, -1, -1);
    repeat (3) run_tile(2, 2, 1'($urandom), -1, -1, -1);
    if (PAD) begin
      run_tile(2, 0, 0, 2, 1, -1);
      run_tile(2, 2, 0, int'($urandom_range(0, DIM-2)), int'($urandom_range(0, WPR-1)), -1);
      run_tile(2, 1, 0, 0, 0, -1);
      run_tile(2, 0, 0, DIM-1, 0, -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
